// File: rtl/fighter_health_bar.sv
// rtl/fighter_health_bar.sv - per-player health, invulnerability/KO tracking and health-bar geometry
module fighter_health_bar #(
    parameter int          MAX_HP      = 28,
    parameter int          PX_PER_HP   = 5,
    parameter int          PUNCH_DMG   = 1,
    parameter int          KICK_DMG    = 2,
    parameter int          IFRAMES     = 30,
    parameter int          BAR_X       = 50,
    parameter int          BAR_Y       = 50,
    parameter int          BAR_H       = 10,
    parameter int          MIRROR      = 0,
    parameter logic [7:0]  RESTART_KEY = 8'h15,
    parameter logic [2:0]  FIGHT_MODE  = 3'd1
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       hit_valid,
    input  logic       hit_type,
    input  logic [7:0] keycode,
    input  logic [2:0] game_mode,
    output logic [7:0] hp,
    output logic       invuln,
    output logic       lose,
    output logic [9:0] redposx,
    output logic [9:0] greenposx,
    output logic [9:0] barposy,
    output logic [9:0] redsizex,
    output logic [9:0] greensizex,
    output logic [9:0] barsizey
);

    localparam int              BAR_W    = MAX_HP * PX_PER_HP;
    localparam int              CW       = (IFRAMES > 1) ? $clog2(IFRAMES) : 1;
    localparam logic [7:0]      HP_FULL  = 8'(MAX_HP);
    localparam logic [7:0]      PUNCH    = 8'(PUNCH_DMG);
    localparam logic [7:0]      KICK     = 8'(KICK_DMG);
    localparam logic [CW-1:0]   IFR_LOAD = (IFRAMES > 0) ? CW'(IFRAMES - 1) : '0;
    localparam logic [9:0]      X0       = 10'(BAR_X);
    localparam logic [9:0]      W        = 10'(BAR_W);

    typedef enum logic [1:0] {
        ALIVE,
        INVULN,
        KO
    } state_t;

    state_t        state, state_next;
    logic [7:0]    hp_nxt;
    logic [CW-1:0] ifr_cnt, ifr_nxt;
    logic          hit_ok;
    logic [7:0]    dmg;
    logic [7:0]    hp_hit;
    logic [9:0]    len;

    assign dmg    = hit_type ? KICK : PUNCH;
    assign hit_ok = hit_valid && (game_mode == FIGHT_MODE) && (state == ALIVE);
    // Saturating subtract so a large hit on low health lands on zero, never wraps
    assign hp_hit = (hp > dmg) ? (hp - dmg) : 8'd0;

    always_comb begin
        state_next = state;
        hp_nxt     = hp;
        ifr_nxt    = ifr_cnt;
        case (state)
            ALIVE: begin
                if (hit_ok) begin
                    hp_nxt = hp_hit;
                    if (hp_hit == 8'd0) begin
                        state_next = KO;
                    end else if (IFRAMES != 0) begin
                        state_next = INVULN;
                        ifr_nxt    = IFR_LOAD;
                    end
                end
            end
            INVULN: begin
                if (ifr_cnt == '0) begin
                    state_next = ALIVE;
                end else begin
                    ifr_nxt = ifr_cnt - CW'(1);
                end
            end
            KO: begin
                if (keycode == RESTART_KEY) begin
                    hp_nxt     = HP_FULL;
                    state_next = ALIVE;
                end
            end
            default: begin
                state_next = ALIVE;
            end
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state   <= ALIVE;
            hp      <= HP_FULL;
            ifr_cnt <= '0;
        end else begin
            state   <= state_next;
            hp      <= hp_nxt;
            ifr_cnt <= ifr_nxt;
        end
    end

    assign invuln = (state == INVULN);
    assign lose   = (state == KO);

    // Geometry follows the registered hp, so it trails hp by one frame
    assign len = 10'(hp * PX_PER_HP);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            redsizex   <= W;
            greensizex <= 10'd0;
            redposx    <= X0;
            greenposx  <= (MIRROR != 0) ? X0 : X0 + W;
        end else begin
            redsizex   <= len;
            greensizex <= W - len;
            if (MIRROR != 0) begin
                greenposx <= X0;
                redposx   <= X0 + W - len;
            end else begin
                redposx   <= X0;
                greenposx <= X0 + len;
            end
        end
    end

    assign barposy  = 10'(BAR_Y);
    assign barsizey = 10'(BAR_H);

endmodule

// File: tb/tb_fighter_health_bar.sv
// tb/tb_fighter_health_bar.sv - vector table plus scoreboarded geometry checks for fighter_health_bar
module tb_fighter_health_bar;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b0;
    logic       hit_valid = 1'b0;
    logic       hit_type  = 1'b0;
    logic [7:0] keycode   = 8'h00;
    logic [2:0] game_mode = 3'd1;

    logic [7:0] hp, hp_m;
    logic       invuln, lose, invuln_m, lose_m;
    logic [9:0] redposx, greenposx, barposy, redsizex, greensizex, barsizey;
    logic [9:0] redposx_m, greenposx_m, barposy_m, redsizex_m, greensizex_m, barsizey_m;

    always #5 frame_clk = ~frame_clk;

    fighter_health_bar #(.IFRAMES(4), .MIRROR(0)) dut (
        .frame_clk(frame_clk), .Reset(Reset), .hit_valid(hit_valid), .hit_type(hit_type),
        .keycode(keycode), .game_mode(game_mode), .hp(hp), .invuln(invuln), .lose(lose),
        .redposx(redposx), .greenposx(greenposx), .barposy(barposy),
        .redsizex(redsizex), .greensizex(greensizex), .barsizey(barsizey)
    );

    fighter_health_bar #(.IFRAMES(4), .MIRROR(1)) dut_m (
        .frame_clk(frame_clk), .Reset(Reset), .hit_valid(hit_valid), .hit_type(hit_type),
        .keycode(keycode), .game_mode(game_mode), .hp(hp_m), .invuln(invuln_m), .lose(lose_m),
        .redposx(redposx_m), .greenposx(greenposx_m), .barposy(barposy_m),
        .redsizex(redsizex_m), .greensizex(greensizex_m), .barsizey(barsizey_m)
    );

    typedef struct {
        logic       hv;
        logic       ht;
        logic [7:0] key;
        logic [2:0] mode;
        int         ehp;
        logic       einv;
        logic       elose;
    } vec_t;

    vec_t vecs[18];
    int   hp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cur_hp;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected bar for a given hp, both layouts, bar width 140 at x=50
    task automatic geo(input int h);
        int l;
        l = h * 5;
        chk("redsizex",     redsizex,     l);
        chk("greensizex",   greensizex,   140 - l);
        chk("redposx",      redposx,      50);
        chk("greenposx",    greenposx,    50 + l);
        chk("barposy",      barposy,      50);
        chk("barsizey",     barsizey,     10);
        chk("m_redsizex",   redsizex_m,   l);
        chk("m_greensizex", greensizex_m, 140 - l);
        chk("m_redposx",    redposx_m,    190 - l);
        chk("m_greenposx",  greenposx_m,  50);
    endtask

    task automatic step(input logic hv, input logic ht, input logic [7:0] key, input logic [2:0] mode,
                        input int ehp, input logic einv, input logic elose);
        int g;
        hit_valid = hv;
        hit_type  = ht;
        keycode   = key;
        game_mode = mode;
        @(posedge frame_clk);
        #1;
        chk("hp",       hp,       ehp);
        chk("invuln",   invuln,   einv);
        chk("lose",     lose,     elose);
        chk("m_hp",     hp_m,     ehp);
        chk("m_invuln", invuln_m, einv);
        if (hp_q.size() == 0) begin
            chk("geom_queue_empty", 0, 1);
        end else begin
            g = hp_q.pop_front();
            geo(g);
        end
        hp_q.push_back(ehp);
    endtask

    // One accepted hit followed by the full 4-frame invulnerability window
    task automatic hit_wait(input logic ht, input logic [7:0] key);
        int d;
        d = ht ? 2 : 1;
        cur_hp = (cur_hp > d) ? cur_hp - d : 0;
        if (cur_hp == 0) begin
            step(1'b1, ht, key, 3'd1, 0, 1'b0, 1'b1);
        end else begin
            step(1'b1, ht, key, 3'd1, cur_hp, 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0, key, 3'd1, cur_hp, 1'b1, 1'b0);
            step(1'b0, 1'b0, key, 3'd1, cur_hp, 1'b0, 1'b0);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 3'd1, 28, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'h00, 3'd1, 26, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 3'd1, 26, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 3'd1, 26, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 3'd1, 26, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 3'd1, 26, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 3'd1, 25, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 3'd1, 25, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 3'd1, 25, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 3'd1, 25, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 3'd1, 25, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 3'd1, 24, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 3'd1, 24, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 3'd1, 24, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 3'd1, 24, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 8'h00, 3'd1, 24, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 8'h00, 3'd0, 24, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 8'h15, 3'd1, 24, 1'b0, 1'b0};

        #1 Reset = 1'b1;
        #10;
        chk("rst_hp",     hp,     28);
        chk("rst_invuln", invuln, 0);
        chk("rst_lose",   lose,   0);
        geo(28);
        @(negedge frame_clk);
        Reset = 1'b0;
        hp_q.push_back(28);

        for (int i = 0; i < 18; i++)
            step(vecs[i].hv, vecs[i].ht, vecs[i].key, vecs[i].mode, vecs[i].ehp, vecs[i].einv, vecs[i].elose);

        cur_hp = 24;
        hit_wait(1'b1, 8'h15);
        hit_wait(1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h15, 3'd1, 20, 1'b0, 1'b0);

        while (cur_hp > 2) hit_wait(1'b1, 8'h00);
        hit_wait(1'b0, 8'h00);
        hit_wait(1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h00, 3'd1, 0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h16, 3'd1, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h15, 3'd1, 28, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 3'd1, 28, 1'b0, 1'b0);

        cur_hp = 28;
        hit_wait(1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h00, 3'd2, 27, 1'b0, 1'b0);

        step(1'b1, 1'b1, 8'h00, 3'd1, 25, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 3'd1, 25, 1'b1, 1'b0);
        #3 Reset = 1'b1;
        #1;
        chk("midrst_hp",     hp,     28);
        chk("midrst_invuln", invuln, 0);
        chk("midrst_lose",   lose,   0);
        geo(28);
        hp_q.delete();
        hp_q.push_back(28);
        @(negedge frame_clk);
        Reset = 1'b0;
        step(1'b0, 1'b0, 8'h00, 3'd1, 28, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 3'd1, 28, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fighter_health_bar.md
# fighter_health_bar

Parametrised per-player health tracker and health-bar geometry generator for the fighting-game datapath. Once per frame it accepts hit events from the collision logic and subtracts a per-attack damage amount. It enforces an invulnerability window after each hit, flags a knockout, and restarts on a key press. It drives the red (remaining) and green (lost) rectangle coordinates consumed by the colour mapper, with an optional mirrored layout for the right-hand player.

## Interface
Parameters:
- MAX_HP, 28, full health in HP units; 1..255.
- PX_PER_HP, 5, bar pixels per HP unit. Bar width is BAR_W = MAX_HP*PX_PER_HP (localparam) and must be ≤ 1023 - BAR_X.
- PUNCH_DMG, 1, HP removed by a punch; ≥ 1.
- KICK_DMG, 2, HP removed by a kick; ≥ 1.
- IFRAMES, 30, frames during which further hits are ignored after a non-fatal hit; 0 disables the window.
- BAR_X, 50, left x of the bar.
- BAR_Y, 50, top y of the bar.
- BAR_H, 10, bar height.
- MIRROR, 0:
  - 0: red is anchored left and green sits on the right.
  - 1: red is anchored right and green sits on the left.
- RESTART_KEY, 8'h15, keycode that revives the player from KO.
- FIGHT_MODE, 3'd1, game_mode value in which hits count.

Ports:
- frame_clk  in  1  frame clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- hit_valid  in  1  a hit landed on this player this frame.
- hit_type  in  1  0 = punch, 1 = kick; sampled only with hit_valid.
- keycode  in  8  current keyboard code.
- game_mode  in  3  global game mode.
- hp  out  8  current health, 0..MAX_HP.
- invuln  out  1  invulnerability window active.
- lose  out  1  player is knocked out.
- redposx, greenposx, barposy  out  10 each  rectangle x positions and shared y.
- redsizex, greensizex, barsizey  out  10 each  rectangle widths and shared height.

## Operation
- FSM states: ALIVE, INVULN, KO.
- A hit is accepted when hit_valid=1, game_mode==FIGHT_MODE and the state is ALIVE. Set dmg = hit_type ? KICK_DMG : PUNCH_DMG.
  - hp_next = (hp > dmg) ? hp - dmg : 0. Subtraction saturates and never wraps.
  - If hp_next==0, go to KO.
  - Else if IFRAMES==0, stay in ALIVE.
  - Else go to INVULN and load ifr_cnt = IFRAMES-1.
- INVULN:
  - All hits are ignored.
  - If ifr_cnt==0, go to ALIVE on the next edge; otherwise ifr_cnt decrements.
  - invuln=1 for exactly IFRAMES frames.
- KO:
  - lose=1 and hits are ignored.
  - keycode==RESTART_KEY sets hp to MAX_HP and goes to ALIVE.
  - RESTART_KEY in ALIVE or INVULN has no effect.
- A hit outside FIGHT_MODE is ignored in every state and does not start the invulnerability window.
- invuln = (state==INVULN) and lose = (state==KO), decoded from the state register with no extra delay.
- Geometry is registered from hp. Let L = hp*PX_PER_HP, using a 10-bit or wider product.
  - redsizex = L and greensizex = BAR_W - L.
  - MIRROR=0: redposx = BAR_X and greenposx = BAR_X + L.
  - MIRROR=1: greenposx = BAR_X and redposx = BAR_X + BAR_W - L.
  - barposy = BAR_Y and barsizey = BAR_H are constant.
- Invariant: redsizex + greensizex == BAR_W at all times.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State and counters: state=ALIVE, hp=MAX_HP, ifr_cnt=0, invuln=0, lose=0.
  - Geometry: redsizex=BAR_W, greensizex=0, barposy=BAR_Y, barsizey=BAR_H.
  - MIRROR=0: redposx=BAR_X, greenposx=BAR_X+BAR_W.
  - MIRROR=1: redposx=BAR_X, greenposx=BAR_X.
- Inputs are sampled at frame edge k.
  - hp, state, invuln and lose change at edge k.
  - Geometry outputs reflect the new hp at edge k+1, giving one frame of latency.
- A hit held for several frames counts once per frame in ALIVE only. The invulnerability window provides the debounce.
- Reset asserted mid-INVULN or mid-KO aborts immediately and returns to the reset values.

## Test plan
All scenarios use defaults except IFRAMES=4, with game_mode=FIGHT_MODE unless stated.
- Reset release, then idle: hp=28, redsizex=140, greensizex=0, greenposx=190, lose=0, invuln=0.
- Single kick at edge k:
  - At edge k: hp=26 and invuln=1.
  - At edge k+1: redsizex=130, greenposx=180, greensizex=10.
  - invuln drops after exactly 4 frames.
- hit_valid held high for 10 frames (punch): hits land at k and k+5, hp=26 afterwards. Frames inside the window are ignored.
- Knockout:
  - Run hp down to 1, then apply a kick: hp=0 (saturated), lose=1, invuln=0.
  - Following geometry: redsizex=0, greensizex=140, greenposx=50.
  - Further hits leave hp at 0.
- Restart key in KO:
  - keycode=8'h15 in KO gives hp=28, lose=0, and the bar is full one frame later.
  - keycode=8'h15 while ALIVE at hp=20 leaves hp=20.
- MIRROR=1, one punch: redposx=55, redsizex=135, greenposx=50, greensizex=5.
  - Hit with game_mode≠FIGHT_MODE gives no change.
  - Reset asserted mid-INVULN restores hp=28 and invuln=0 asynchronously.
